pgr_uart_cmd_parser_32bit: RTL and testbench



---
 rtl/pgr_uart_cmd_parser_32bit_if.sv | 28 ++
 rtl/pgr_uart_cmd_parser_32bit.sv | 153 +++++++++++++++
 tb/tb_pgr_uart_cmd_parser_32bit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pgr_uart_cmd_parser_32bit_if.sv
// Command-port bundle between the UART RX byte source / APB master and the frame parser.
// master = UART RX and APB master side, slave = the parser itself.
interface pgr_uart_cmd_parser_32bit_if #(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int SW = 4
);
    logic [7:0]    rx_data;
    logic          rx_vld;
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          cmd_en;
    logic          cmd_done;
    logic          busy;
    logic          frame_err;

    modport master (
        output rx_data, rx_vld, cmd_done,
        input  strb, addr, wdata, we, cmd_en, busy, frame_err
    );

    modport slave (
        input  rx_data, rx_vld, cmd_done,
        output strb, addr, wdata, we, cmd_en, busy, frame_err
    );
endinterface

// File: rtl/pgr_uart_cmd_parser_32bit.sv
// Assembles UART bytes (header, address MSB-first, write data LSB-first) into one APB
// command, strobes cmd_en once and waits for cmd_done before accepting the next header.
module pgr_uart_cmd_parser_32bit #(
    parameter int CLK_FREQ = 50,
    parameter int BAUD     = 115200,
    parameter int AW       = 24,
    parameter int DW       = 32,
    parameter int SW       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pgr_uart_cmd_parser_32bit_if.slave  bus
);

    // Inter-byte timeout: 30 bit times, roughly three UART characters of silence.
    localparam int unsigned GAP_TO    = 30 * ((CLK_FREQ * 1000000) / BAUD);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_TO - 1);
    localparam logic [2:0]  ADDR_LAST = 3'(AW / 8 - 1);
    localparam logic [2:0]  DATA_LAST = 3'(DW / 8 - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [15:0]   gap_q, gap_d;
    logic [SW-1:0] strb_q, strb_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          cmd_en_q, cmd_en_d;
    logic          busy_q, busy_d;
    logic          frame_err_q, frame_err_d;

    logic [AW+7:0] addr_shift;
    logic [DW+7:0] wdata_shift;
    logic          gap_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = '0;
        strb_d      = strb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        frame_err_d = 1'b0;

        // Wide concatenations keep the shifts legal even for 8-bit AW/DW.
        addr_shift  = {addr_q, bus.rx_data};
        wdata_shift = {bus.rx_data, wdata_q};
        // A byte arriving in the timeout cycle wins over the timeout.
        gap_hit     = (gap_q == GAP_LAST) && !bus.rx_vld;

        case (state_q)
            IDLE: begin
                if (bus.rx_vld) begin
                    we_d    = bus.rx_data[7];
                    strb_d  = bus.rx_data[SW-1:0];
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.rx_vld) begin
                    addr_d = addr_shift[AW-1:0];
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = we_q ? DATA : ISSUE;
                    end
                end else if (gap_hit) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            DATA: begin
                if (bus.rx_vld) begin
                    wdata_d = wdata_shift[DW+7:8];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = ISSUE;
                    end
                end else if (gap_hit) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            ISSUE: begin
                frame_err_d = bus.rx_vld;
                state_d     = WAIT;
            end
            WAIT: begin
                // Bytes are dropped even in the cycle cmd_done is seen.
                frame_err_d = bus.rx_vld;
                if (bus.cmd_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_en_d = (state_d == ISSUE) && (state_q != ISSUE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            strb_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cmd_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            strb_q      <= strb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cmd_en_q    <= cmd_en_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.strb      = strb_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.we        = we_q;
    assign bus.cmd_en    = cmd_en_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_pgr_uart_cmd_parser_32bit.sv
// Bench for the UART command parser: expected commands are queued as frames are sent
// and compared by a monitor whenever cmd_en fires.
module tb_pgr_uart_cmd_parser_32bit;
    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int SW     = 4;
    localparam int GAP_TO = 30 * ((50 * 1000000) / 115200);

    typedef struct packed {
        logic          we;
        logic [SW-1:0] strb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pgr_uart_cmd_parser_32bit_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

    pgr_uart_cmd_parser_32bit #(
        .CLK_FREQ(50), .BAUD(115200), .AW(AW), .DW(DW), .SW(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cmd_t exp_q[$];
    cmd_t mon_got, mon_exp;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   cmd_cnt = 0;
    int   err_cnt = 0;
    bit   pending = 1'b0;

    // Scoreboard monitor: every cmd_en pops one expected command.
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.cmd_done === 1'b1) pending = 1'b0;
        if (bus.cmd_en === 1'b1) begin
            cmd_cnt++;
            mon_got = {bus.we, bus.strb, bus.addr, bus.wdata};
            n_chk++;
            if (pending) $display("FAIL cmd_en_repeat: cmd_en=1 with a command outstanding, required no cmd_en");
            else n_pass++;
            pending = 1'b1;
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL cmd_unexpected: got we=%0b strb=%h addr=%h wdata=%h, required no command",
                         mon_got.we, mon_got.strb, mon_got.addr, mon_got.wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL cmd_fields: got we=%0b strb=%h addr=%h wdata=%h, required we=%0b strb=%h addr=%h wdata=%h",
                             mon_got.we, mon_got.strb, mon_got.addr, mon_got.wdata,
                             mon_exp.we, mon_exp.strb, mon_exp.addr, mon_exp.wdata);
                else n_pass++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_vld  = 1'b1;
        @(posedge clk); #1;
        bus.rx_vld  = 1'b0;
    endtask

    task automatic complete_cmd();
        @(posedge clk); #1;
        bus.cmd_done = 1'b1;
        @(posedge clk); #1;
        bus.cmd_done = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_data  = 8'h00;
        bus.rx_vld   = 1'b0;
        bus.cmd_done = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.strb !== 4'h0) $display("FAIL rst_strb: got %h, required 0", bus.strb); else n_pass++;
        n_chk++; if (bus.addr !== 24'h0) $display("FAIL rst_addr: got %h, required 0", bus.addr); else n_pass++;
        n_chk++; if (bus.wdata !== 32'h0) $display("FAIL rst_wdata: got %h, required 0", bus.wdata); else n_pass++;
        n_chk++; if (bus.we !== 1'b0) $display("FAIL rst_we: got %b, required 0", bus.we); else n_pass++;
        n_chk++; if (bus.cmd_en !== 1'b0) $display("FAIL rst_cmd_en: got %b, required 0", bus.cmd_en); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.busy); else n_pass++;
        n_chk++; if (bus.frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b, required 0", bus.frame_err); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_release_busy: got %b, required 0", bus.busy); else n_pass++;
    endtask

    task automatic test_write_frame();
        logic [7:0] f [0:7];
        f = '{8'h8F, 8'h12, 8'h34, 8'h56, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_q.push_back({1'b1, 4'hF, 24'h123456, 32'hDEADBEEF});
        for (int i = 0; i < 8; i++) begin
            send_byte(f[i]);
            if (i == 0) begin
                @(negedge clk);
                n_chk++; if (bus.busy !== 1'b1) $display("FAIL wr_busy_rise: got %b, required 1", bus.busy); else n_pass++;
            end
            if (i < 7) repeat (8) @(posedge clk);
        end
        @(negedge clk);
        n_chk++; if (bus.cmd_en !== 1'b1) $display("FAIL wr_cmd_en: got %b, required 1", bus.cmd_en); else n_pass++;
        n_chk++; if (bus.we !== 1'b1) $display("FAIL wr_we: got %b, required 1", bus.we); else n_pass++;
        n_chk++; if (bus.strb !== 4'hF) $display("FAIL wr_strb: got %h, required f", bus.strb); else n_pass++;
        n_chk++; if (bus.addr !== 24'h123456) $display("FAIL wr_addr: got %h, required 123456", bus.addr); else n_pass++;
        n_chk++; if (bus.wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata: got %h, required deadbeef", bus.wdata); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.cmd_en !== 1'b0) $display("FAIL wr_cmd_en_single: got %b, required 0", bus.cmd_en); else n_pass++;
        repeat (5) @(negedge clk);
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL wr_busy_wait: got %b, required 1", bus.busy); else n_pass++;
        @(posedge clk); #1;
        bus.cmd_done = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL wr_busy_at_done: got %b, required 1", bus.busy); else n_pass++;
        @(posedge clk); #1;
        bus.cmd_done = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL wr_busy_after_done: got %b, required 0", bus.busy); else n_pass++;
    endtask

    task automatic test_read_frame();
        logic [7:0] f [0:3];
        f = '{8'h03, 8'h00, 8'h00, 8'h10};
        exp_q.push_back({1'b0, 4'h3, 24'h000010, 32'hDEADBEEF});
        foreach (f[i]) send_byte(f[i]);
        @(negedge clk);
        n_chk++; if (bus.cmd_en !== 1'b1) $display("FAIL rd_cmd_en: got %b, required 1", bus.cmd_en); else n_pass++;
        n_chk++; if (bus.we !== 1'b0) $display("FAIL rd_we: got %b, required 0", bus.we); else n_pass++;
        n_chk++; if (bus.addr !== 24'h000010) $display("FAIL rd_addr: got %h, required 000010", bus.addr); else n_pass++;
        n_chk++; if (bus.wdata !== 32'hDEADBEEF) $display("FAIL rd_wdata_kept: got %h, required deadbeef", bus.wdata); else n_pass++;
        complete_cmd();
    endtask

    task automatic test_gap_timeout();
        int e0, c0;
        logic [7:0] f [0:3];
        e0 = err_cnt;
        c0 = cmd_cnt;
        send_byte(8'h8F);
        send_byte(8'h12);
        @(negedge clk);
        repeat (GAP_TO - 1) @(negedge clk);
        n_chk++; if (bus.frame_err !== 1'b0) $display("FAIL gap_early: got frame_err=%b, required 0", bus.frame_err); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.frame_err !== 1'b1) $display("FAIL gap_frame_err: got %b, required 1", bus.frame_err); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL gap_busy: got %b, required 0", bus.busy); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.frame_err !== 1'b0) $display("FAIL gap_err_single: got %b, required 0", bus.frame_err); else n_pass++;
        n_chk++; if (err_cnt - e0 != 1) $display("FAIL gap_err_count: got %0d, required 1", err_cnt - e0); else n_pass++;
        n_chk++; if (cmd_cnt != c0) $display("FAIL gap_no_cmd: got %0d commands, required %0d", cmd_cnt, c0); else n_pass++;
        f = '{8'h05, 8'h01, 8'h02, 8'h03};
        exp_q.push_back({1'b0, 4'h5, 24'h010203, 32'hDEADBEEF});
        foreach (f[i]) send_byte(f[i]);
        @(negedge clk);
        n_chk++; if (bus.cmd_en !== 1'b1) $display("FAIL gap_recover_cmd_en: got %b, required 1", bus.cmd_en); else n_pass++;
        complete_cmd();
    endtask

    task automatic test_hold_done();
        int e0;
        logic [7:0] f [0:3];
        f = '{8'h02, 8'hAB, 8'hCD, 8'hEF};
        exp_q.push_back({1'b0, 4'h2, 24'hABCDEF, 32'hDEADBEEF});
        foreach (f[i]) send_byte(f[i]);
        @(negedge clk);
        n_chk++; if (bus.cmd_en !== 1'b1) $display("FAIL hold_cmd_en: got %b, required 1", bus.cmd_en); else n_pass++;
        repeat (3) @(posedge clk);
        e0 = err_cnt;
        send_byte(8'h55);
        @(negedge clk);
        n_chk++; if (bus.frame_err !== 1'b1) $display("FAIL hold_drop_err: got %b, required 1", bus.frame_err); else n_pass++;
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL hold_busy: got %b, required 1", bus.busy); else n_pass++;
        @(posedge clk); #1;
        bus.cmd_done = 1'b1;
        bus.rx_data  = 8'h77;
        bus.rx_vld   = 1'b1;
        @(posedge clk); #1;
        bus.cmd_done = 1'b0;
        bus.rx_data  = 8'h01;
        @(negedge clk);
        n_chk++; if (bus.frame_err !== 1'b1) $display("FAIL hold_done_drop_err: got %b, required 1", bus.frame_err); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL hold_busy_clear: got %b, required 0", bus.busy); else n_pass++;
        @(posedge clk); #1;
        bus.rx_vld = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL hold_header_busy: got %b, required 1", bus.busy); else n_pass++;
        exp_q.push_back({1'b0, 4'h1, 24'h000020, 32'hDEADBEEF});
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h20);
        @(negedge clk);
        n_chk++; if (bus.addr !== 24'h000020) $display("FAIL hold_next_addr: got %h, required 000020", bus.addr); else n_pass++;
        n_chk++; if (bus.strb !== 4'h1) $display("FAIL hold_next_strb: got %h, required 1", bus.strb); else n_pass++;
        complete_cmd();
        n_chk++; if (err_cnt - e0 != 2) $display("FAIL hold_err_count: got %0d, required 2", err_cnt - e0); else n_pass++;
    endtask

    task automatic test_gap_edge();
        int e0;
        logic [7:0] f [0:4];
        e0 = err_cnt;
        exp_q.push_back({1'b1, 4'hA, 24'h112233, 32'h12345678});
        send_byte(8'h8A);
        send_byte(8'h11);
        repeat (GAP_TO - 2) @(posedge clk);
        send_byte(8'h22);
        @(negedge clk);
        n_chk++; if (bus.frame_err !== 1'b0) $display("FAIL edge_no_err: got %b, required 0", bus.frame_err); else n_pass++;
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL edge_busy: got %b, required 1", bus.busy); else n_pass++;
        f = '{8'h33, 8'h78, 8'h56, 8'h34, 8'h12};
        foreach (f[i]) send_byte(f[i]);
        @(negedge clk);
        n_chk++; if (bus.cmd_en !== 1'b1) $display("FAIL edge_cmd_en: got %b, required 1", bus.cmd_en); else n_pass++;
        n_chk++; if (bus.addr !== 24'h112233) $display("FAIL edge_addr: got %h, required 112233", bus.addr); else n_pass++;
        n_chk++; if (bus.wdata !== 32'h12345678) $display("FAIL edge_wdata: got %h, required 12345678", bus.wdata); else n_pass++;
        complete_cmd();
        n_chk++; if (err_cnt != e0) $display("FAIL edge_err_count: got %0d, required %0d", err_cnt, e0); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] f [0:3];
        send_byte(8'h8F);
        send_byte(8'h11);
        send_byte(8'h22);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.strb !== 4'h0) $display("FAIL mid_rst_strb: got %h, required 0", bus.strb); else n_pass++;
        n_chk++; if (bus.addr !== 24'h0) $display("FAIL mid_rst_addr: got %h, required 0", bus.addr); else n_pass++;
        n_chk++; if (bus.wdata !== 32'h0) $display("FAIL mid_rst_wdata: got %h, required 0", bus.wdata); else n_pass++;
        n_chk++; if (bus.we !== 1'b0) $display("FAIL mid_rst_we: got %b, required 0", bus.we); else n_pass++;
        n_chk++; if (bus.cmd_en !== 1'b0) $display("FAIL mid_rst_cmd_en: got %b, required 0", bus.cmd_en); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy: got %b, required 0", bus.busy); else n_pass++;
        n_chk++; if (bus.frame_err !== 1'b0) $display("FAIL mid_rst_frame_err: got %b, required 0", bus.frame_err); else n_pass++;
        pending = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        f = '{8'h0F, 8'hAA, 8'hBB, 8'hCC};
        exp_q.push_back({1'b0, 4'hF, 24'hAABBCC, 32'h0});
        foreach (f[i]) send_byte(f[i]);
        @(negedge clk);
        n_chk++; if (bus.cmd_en !== 1'b1) $display("FAIL mid_cmd_en: got %b, required 1", bus.cmd_en); else n_pass++;
        n_chk++; if (bus.addr !== 24'hAABBCC) $display("FAIL mid_addr: got %h, required aabbcc", bus.addr); else n_pass++;
        n_chk++; if (bus.wdata !== 32'h0) $display("FAIL mid_wdata: got %h, required 0", bus.wdata); else n_pass++;
        complete_cmd();
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_read_frame();
        test_gap_timeout();
        test_hold_done();
        test_gap_edge();
        test_reset_midframe();
        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d commands outstanding, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
